// File: rtl/dff_asynch_pkg.sv
// rtl/dff_asynch_pkg.sv - shared constants and types for the async-reset register
package dff_asynch_pkg;

    localparam int DFF_DEFAULT_WIDTH = 1;
    localparam int DFF_MAX_WIDTH     = 64;

    // Every async-reset block compares against this so the polarity lives in one place.
    localparam logic RST_ACTIVE = 1'b0;

    typedef logic [DFF_MAX_WIDTH-1:0] rst_val_t;

endpackage

// File: rtl/dff_asynch_bit.sv
// rtl/dff_asynch_bit.sv - single-bit D flop with asynchronous active-low reset
module dff_asynch_bit
    import dff_asynch_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (reset == RST_ACTIVE) begin
            q <= RESET_BIT;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_asynch.sv
// rtl/dff_asynch.sv - WIDTH-bit D register with asynchronous active-low reset
module dff_asynch
    import dff_asynch_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_asynch_bit #(
            .RESET_BIT (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .d     (D[i]),
            .q     (Q[i])
        );
    end

    // Derived from Q rather than stored, so it can never disagree with it.
    assign Qn = ~Q;

endmodule

// File: tb/tb_dff_asynch.sv
// tb/tb_dff_asynch.sv - self-checking bench for dff_asynch (1-bit and 8-bit instances)
module tb_dff_asynch;

    localparam logic [7:0] RV8 = 8'hA5;
    localparam logic       RV1 = 1'b0;

    logic       clk = 1'b0;
    logic       reset;
    logic       d1;
    logic       q1;
    logic       qn1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    logic       exp1;
    logic [7:0] exp8;

    int vectors     = 0;
    int miscompares = 0;

    dff_asynch u_dut1 (
        .clk   (clk),
        .reset (reset),
        .D     (d1),
        .Q     (q1),
        .Qn    (qn1)
    );

    dff_asynch #(
        .WIDTH     (8),
        .RESET_VAL (RV8)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .D     (d8),
        .Q     (q8),
        .Qn    (qn8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q1"},  {7'd0, q1},   {7'd0, exp1});
        chk({tag, ".qn1"}, {7'd0, qn1},  {7'd0, ~exp1});
        chk({tag, ".q8"},  q8,  exp8);
        chk({tag, ".qn8"}, qn8, ~exp8);
    endtask

    // Reference rule: a rising edge loads D only if reset was already released.
    task automatic model_edge(input logic rst_at_edge);
        exp1 = rst_at_edge ? d1 : RV1;
        exp8 = rst_at_edge ? d8 : RV8;
    endtask

    task automatic cycle(input logic r, input logic dv1, input logic [7:0] dv8, input string tag);
        @(negedge clk);
        reset = r;
        d1    = dv1;
        d8    = dv8;
        @(posedge clk);
        model_edge(r);
        #1;
        chk_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        d1    = 1'b1;
        d8    = 8'hFF;

        // Async reset before any clock edge (first rise is at 5 ns).
        #2 reset = 1'b0;
        #1;
        exp1 = RV1;
        exp8 = RV8;
        chk_all("reset_no_clk");

        @(posedge clk);
        #1;
        chk_all("reset_holds_edge");

        // Release at 10 ns; capture 1 at 15 ns, then 0 at 25 ns.
        cycle(1'b1, 1'b1, 8'hFF, "capture_1");
        cycle(1'b1, 1'b0, 8'h3C, "capture_0");
        cycle(1'b1, 1'b1, 8'h3C, "capture_1b");

        // D glitches between edges must not disturb Q.
        #2 d1 = 1'b0; d8 = 8'h00;
        #2 d1 = 1'b1; d8 = 8'h3C;
        #1;
        chk_all("glitch_immune");

        // Mid-cycle reset overrides immediately and holds across edges.
        #1 reset = 1'b0;
        #1;
        exp1 = RV1;
        exp8 = RV8;
        chk_all("mid_reset");
        cycle(1'b0, 1'b1, 8'h77, "reset_hold_a");
        cycle(1'b0, 1'b1, 8'h5A, "reset_hold_b");

        // Release coincident with a rising edge: nonblocking so the flop sees reset still low.
        @(posedge clk);
        reset <= 1'b1;
        #1;
        chk_all("release_at_edge");
        @(posedge clk);
        model_edge(1'b1);
        #1;
        chk_all("first_capture_after_release");

        // {reset, D} sweep: expected Q after edges 0, 0, 0, 1.
        cycle(1'b0, 1'b0, 8'h00, "sweep_00");
        cycle(1'b0, 1'b1, 8'hFF, "sweep_01");
        cycle(1'b1, 1'b0, 8'h00, "sweep_10");
        cycle(1'b1, 1'b1, 8'hFF, "sweep_11");

        // Randomised traffic with occasional mid-cycle resets.
        for (int i = 0; i < 60; i++) begin
            logic       r;
            logic       rv;
            logic [7:0] dv;
            r  = ($urandom_range(0, 5) != 0);
            rv = 1'($urandom);
            dv = 8'($urandom);
            cycle(r, rv, dv, "random_edge");
            if ($urandom_range(0, 7) == 0) begin
                #2 reset = 1'b0;
                #1;
                exp1 = RV1;
                exp8 = RV8;
                chk_all("random_mid_reset");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dff_asynch.md
Name: dff_asynch

Overview:
- Edge-triggered D-type storage register with asynchronous, active-low reset.
- Captures input D on each rising clock edge and holds it on Q until the next rising edge.
- Q is forced to a defined reset value whenever reset is low, independent of the clock.
- Used as the basic state-holding element in clocked datapaths and control logic; WIDTH lets one instance replace a bank of single-bit flops.

Parameters:
- WIDTH, 1, number of bits stored; D, Q and Qn are all WIDTH bits wide.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q while reset is asserted.

Ports:
- clk  input  1  clock; rising-edge active.
- reset  input  1  asynchronous active-low reset; 0 = reset asserted, 1 = normal operation.
- D  input  WIDTH  data to capture.
- Q  output  WIDTH  registered data.
- Qn  output  WIDTH  bitwise complement of Q; may be left unconnected.

Behaviour:
- Reset assertion:
  - When reset goes low, Q = RESET_VAL and Qn = ~RESET_VAL immediately, with no clock edge required.
  - Outputs hold these values for as long as reset is low; clk and D are ignored.
- Reset deassertion:
  - When reset goes high, Q keeps RESET_VAL.
  - The first capture happens on the first rising clk edge strictly after the release.
  - If release coincides with a rising clk edge, reset dominates: that edge does not capture, and Q stays RESET_VAL until the next rising edge.
- Normal operation (reset high):
  - On each rising clk edge, Q <= D, sampled at the edge.
  - Latency is one clock edge from D to Q.
  - Falling edges and D changes between edges have no effect on Q.
- Qn is a combinational inverse of Q at all times; it is not a separate register, so it can never disagree with ~Q.
- Reset asserted mid-cycle overrides any pending capture.
- Each bit is independent; there is no cross-bit logic.
- No enable, no synchronous clear, no X-propagation masking. An X on D is captured as X.
- Power-up state before the first reset or clock edge is undefined. Benches must apply reset before checking Q.

Decomposition:
- Shared package:
  - Default-width constant DFF_DEFAULT_WIDTH = 1.
  - Logic-vector typedef for reset values.
  - Reset polarity constant RST_ACTIVE = 1'b0, so all async-reset blocks agree.
- Sub-module dff_asynch_bit: one single-bit flop with the same clock/reset semantics and a per-bit reset value.
  - dff_asynch instantiates WIDTH copies via a generate loop.
  - Qn is derived at the top level.

Test Plan:
- Async reset, no clock:
  - Hold clk = 0, set D = 1, drive reset = 0.
  - Required: Q = 0 and Qn = 1 within the same timestep, with no clk edge.
- Capture 1, then 0 (clk period 10 ns, rising edges at 5, 15, 25 ...):
  - With reset = 1, set D = 1 before the 15 ns edge. Required: Q = 1 and Qn = 0 after the 15 ns edge.
  - Then set D = 0 before the 25 ns edge. Required: Q = 0 after the 25 ns edge.
- Reset-dominates-release:
  - Release reset (0 -> 1) exactly at a rising clk edge with D = 1.
  - Required: Q stays 0 at that edge and becomes 1 only at the following rising edge.
- Mid-cycle glitch immunity and mid-operation reset:
  - With reset = 1, Q = 1, toggle D 1 -> 0 -> 1 between rising edges. Required: Q stays 1.
  - Then pull reset = 0 mid-cycle. Required: Q = 0 immediately, and Q holds 0 across subsequent edges while reset stays low.
- Sequenced sweep of {reset, D} = 00, 01, 10, 11, each held 10 ns with a 10 ns clock:
  - Required Q after each rising edge: 0, 0, 0, 1.
  - Qn must equal ~Q throughout.
- WIDTH = 8, RESET_VAL = 8'hA5:
  - Assert reset. Required: Q = 8'hA5.
  - Release reset, then D = 8'h3C at a rising edge. Required: Q = 8'h3C and Qn = 8'hC3.
